// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_iter
// Brief    : Handshaked AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE
//            columns per beat. Optional MIX_COLUMNS_BYPASS_EN adds in_bypass.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
`ifdef MIX_COLUMNS_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         BEATS     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0e*x, 0b*x, 0d*x, 09*x}, sharing one xtime chain.
  function automatic logic [31:0] inv_products(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [31:0] p0, p1, p2, p3;
    p0 = inv_products(c[31:24]);
    p1 = inv_products(c[23:16]);
    p2 = inv_products(c[15:8]);
    p3 = inv_products(c[7:0]);
    // Product lanes: [31:24]=0e, [23:16]=0b, [15:8]=0d, [7:0]=09
    return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
            p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
            p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
            p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic           inv_q, inv_d;
  logic [127:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
`ifdef MIX_COLUMNS_BYPASS_EN
  logic           bypass_q, bypass_d;
`endif

  logic [32*COLS_PER_CYCLE-1:0] mixed_flat;

  // --------------------------------------------------------------------------
  // Column units: unit u handles column cnt*COLS_PER_CYCLE+u this beat
  // --------------------------------------------------------------------------
  generate
    for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
      logic [1:0]  col_idx;
      logic [31:0] src_col;
      logic [31:0] unit_out;

      assign col_idx = 2'(int'(cnt_q) * COLS_PER_CYCLE + u);
      assign src_col = work_q[{col_idx, 5'd0} +: 32];

      always_comb begin
        unit_out = inv_q ? mix_inv(src_col) : mix_fwd(src_col);
`ifdef MIX_COLUMNS_BYPASS_EN
        if (bypass_q) begin
          unit_out = src_col;
        end
`endif
      end

      assign mixed_flat[32*u +: 32] = unit_out;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM / datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      work_q      <= 128'd0;
      inv_q       <= 1'b0;
      out_data_q  <= 128'd0;
      out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MIX_COLUMNS_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

  always_comb begin
    logic [1:0] idx;
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    inv_d       = inv_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MIX_COLUMNS_BYPASS_EN
    bypass_d    = bypass_q;
`endif
    idx         = 2'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
`ifdef MIX_COLUMNS_BYPASS_EN
          bypass_d = in_bypass;
`endif
          cnt_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Columns outside this beat keep whatever out_data held before.
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
          idx = 2'(int'(cnt_q) * COLS_PER_CYCLE + u);
          out_data_d[{idx, 5'd0} +: 32] = mixed_flat[32*u +: 32];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_BEAT) begin
          cnt_d       = 2'd0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_iter
// Brief    : Self-checking bench; three engines (1, 2, 4 columns per beat)
//            against a matrix-product GF(2^8) reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

  localparam logic [127:0] C_VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] C_VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] C_VEC_P = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic         out_valid_a [3];
  logic         in_ready_a  [3];
  logic         busy_a      [3];
  logic [127:0] out_data_a  [3];
  logic [127:0] exp_a       [3];
  logic         chk_en_a    [3];
  logic         done_a      [3];

  task automatic check(input string name, input int inst,
                       input logic [127:0] got, input logic [127:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s (cols_per_cycle=%0d) got %h required %h",
                  name, 1 << inst, got, req);
  endtask

  // Generic GF(2^8) multiply: carry-less product reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Output byte r of a column = sum_k M[r][k]*a_k, M[r][k] = base[(k-r) mod 4].
  function automatic logic [127:0] model(input logic [127:0] x, input logic inv,
                                         input logic byp);
    logic [7:0]   base [4];
    logic [127:0] y;
    logic [7:0]   acc;
    if (byp) return x;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    y = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(base[(k - r + 4) % 4], x[32*c + 31 - 8*k -: 8]);
        y[32*c + 31 - 8*r -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Single compare process over all three engines.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (chk_en_a[i] === 1'b1) begin
        check("busy_is_not_ready", i, 128'(busy_a[i]), 128'(!in_ready_a[i]));
        if (out_valid_a[i]) check("out_data", i, out_data_a[i], exp_a[i]);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int CPC = 1 << gi;
      localparam int NB  = 4 / CPC;

      logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
      logic         in_bypass;
      logic [127:0] in_data, out_data, exp_data;
      logic         chk_en, done;

      mix_columns_iter #(.COLS_PER_CYCLE(CPC)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
`ifdef MIX_COLUMNS_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
      );

      assign out_valid_a[gi] = out_valid;
      assign in_ready_a[gi]  = in_ready;
      assign busy_a[gi]      = busy;
      assign out_data_a[gi]  = out_data;
      assign exp_a[gi]       = exp_data;
      assign chk_en_a[gi]    = chk_en;
      assign done_a[gi]      = done;

      // One transaction; returns to the caller at the negedge after out_valid falls.
      task automatic send(input logic [127:0] d, input logic inv, input logic byp,
                          input int hold, input bit decoy, output logic [127:0] res);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 40) begin
          @(negedge clk);
          w++;
        end
        check("in_ready_before_accept", gi, 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = inv;
        in_bypass = byp;
        exp_data  = model(d, inv, byp);
        out_ready = (hold == 0);
        @(negedge clk);
        // Scramble inputs after the handshake; the result must not follow them.
        in_valid  = 1'b0;
        in_inv    = ~inv;
        in_bypass = ~byp;
        in_data   = rand128();
        lat = 0;
        while (!out_valid && lat < 20) begin
          check("in_ready_low_busy", gi, 128'(in_ready), 128'd0);
          @(negedge clk);
          lat++;
        end
        check("latency", gi, 128'(lat), 128'(NB));
        res = out_data;
        for (int h = 0; h < hold; h++) begin
          if (decoy) begin
            in_valid = 1'b1;
            in_data  = rand128();
            in_inv   = $urandom_range(0, 1) != 0;
          end
          check("in_ready_low_done", gi, 128'(in_ready), 128'd0);
          check("out_valid_held", gi, 128'(out_valid), 128'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_fall", gi, 128'(out_valid), 128'd0);
        check("in_ready_return", gi, 128'(in_ready), 128'd1);
      endtask

      task automatic reset_abort();
        in_valid  = 1'b1;
        in_data   = rand128();
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        exp_data  = 128'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", gi, 128'(out_valid), 128'd0);
        check("abort_out_data", gi, out_data, 128'd0);
        check("abort_in_ready", gi, 128'(in_ready), 128'd1);
        check("abort_busy", gi, 128'(busy), 128'd0);
      endtask

      initial begin
        logic [127:0] x, fwd, res;
        logic         inv;
        chk_en    = 1'b0;
        done      = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        in_data   = 128'd0;
        out_ready = 1'b1;
        exp_data  = 128'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", gi, 128'(out_valid), 128'd0);
        check("reset_out_data", gi, out_data, 128'd0);
        check("reset_in_ready", gi, 128'(in_ready), 128'd1);
        check("reset_busy", gi, 128'(busy), 128'd0);
        chk_en = 1'b1;

        send(C_VEC_A, 1'b0, 1'b0, 0, 1'b0, res);
        check("fwd_vector", gi, res, C_VEC_B);
        send(C_VEC_B, 1'b1, 1'b0, 0, 1'b0, res);
        check("inv_vector", gi, res, C_VEC_A);

        // Backpressure with a competing request held during DONE.
        send(rand128(), 1'b0, 1'b0, 10, 1'b1, res);
        send(C_VEC_A, 1'b0, 1'b0, 0, 1'b0, res);
        check("after_backpressure", gi, res, C_VEC_B);

        reset_abort();
        send(C_VEC_B, 1'b1, 1'b0, 0, 1'b0, res);
        check("after_abort", gi, res, C_VEC_A);

`ifdef MIX_COLUMNS_BYPASS_EN
        send(C_VEC_P, 1'b1, 1'b1, 0, 1'b0, res);
        check("bypass_vector", gi, res, C_VEC_P);
`endif

        for (int n = 0; n < 1000; n++) begin
          x   = rand128();
          inv = $urandom_range(0, 1) != 0;
          send(x, inv, 1'b0, $urandom_range(0, 3), 1'b0, res);
          if ((n % 8) == 0) begin
            send(x, 1'b0, 1'b0, 0, 1'b0, fwd);
            send(fwd, 1'b1, 1'b0, 0, 1'b0, res);
            check("round_trip", gi, res, x);
          end
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    int t;
    // Pin the reference model with known FIPS-197 columns.
    check("model_fwd", 0, model(C_VEC_A, 1'b0, 1'b0), C_VEC_B);
    check("model_inv", 0, model(C_VEC_B, 1'b1, 1'b0), C_VEC_A);
    check("model_bypass", 0, model(C_VEC_P, 1'b1, 1'b1), C_VEC_P);
    t = 0;
    while (!(done_a[0] === 1'b1 && done_a[1] === 1'b1 && done_a[2] === 1'b1)
           && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("all_engines_done", 0,
          128'({done_a[0] === 1'b1, done_a[1] === 1'b1, done_a[2] === 1'b1}),
          128'd7);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
